// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC datapath: ALU opcodes, data width,
// IR field positions and CON condition codes.
package mini_src_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_OR   = 5'b00011,
    ALU_SHR  = 5'b00100,
    ALU_SHRA = 5'b00101,
    ALU_SHL  = 5'b00110,
    ALU_ROR  = 5'b00111,
    ALU_ROL  = 5'b01000,
    ALU_MUL  = 5'b01001,
    ALU_DIV  = 5'b01010,
    ALU_NEG  = 5'b01011,
    ALU_NOT  = 5'b01100,
    ALU_INC4 = 5'b01101
  } alu_op_e;

  localparam int IR_REG_W   = 4;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_LSB  = 15;
  localparam int IR_CON_LSB = 19;
  localparam int IR_C_MSB   = 18;

  typedef enum logic [1:0] {
    CON_ZERO    = 2'b00,
    CON_NONZERO = 2'b01,
    CON_GEZ     = 2'b10,
    CON_LTZ     = 2'b11
  } con_cond_e;

  // Evaluates the branch condition encoded in IR[20:19] against a bus value.
  function automatic logic conditionMet(input logic [1:0] code,
                                        input logic [DATA_WIDTH-1:0] value);
    logic met;
    met = 1'b0;
    case (code)
      CON_ZERO:    met = (value == '0);
      CON_NONZERO: met = (value != '0);
      CON_GEZ:     met = ~value[DATA_WIDTH-1];
      CON_LTZ:     met = value[DATA_WIDTH-1];
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/mini_src_alu.sv
// Combinational Mini SRC ALU producing a 64-bit result from (op, A, B).
// MUL/DIV exist only when DATAPATH_MULDIV_EN is defined; otherwise they yield 0.
module mini_src_alu
  import mini_src_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [4:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] result_o
);

  logic [4:0]         shamt;
  logic [2*WIDTH-1:0] dblA;
  logic [2*WIDTH-1:0] rorWide;
  logic [2*WIDTH-1:0] rolWide;

  assign shamt = b_i[4:0];
  // Rotates fall out of shifting A concatenated with itself.
  assign dblA    = {a_i, a_i};
  assign rorWide = dblA >> shamt;
  assign rolWide = dblA << shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [2*WIDTH-1:0] aExt;
  logic signed [2*WIDTH-1:0] bExt;
  logic signed [2*WIDTH-1:0] product;
  logic signed [WIDTH-1:0]   quotient;
  logic signed [WIDTH-1:0]   remainder;

  assign aExt    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign bExt    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign product = aExt * bExt;

  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (b_i != '0) begin
      quotient  = $signed(a_i) / $signed(b_i);
      remainder = $signed(a_i) % $signed(b_i);
    end
  end
`endif

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o[WIDTH-1:0] = a_i + b_i;
      ALU_SUB:  result_o[WIDTH-1:0] = a_i - b_i;
      ALU_AND:  result_o[WIDTH-1:0] = a_i & b_i;
      ALU_OR:   result_o[WIDTH-1:0] = a_i | b_i;
      ALU_SHR:  result_o[WIDTH-1:0] = a_i >> shamt;
      ALU_SHRA: result_o[WIDTH-1:0] = $unsigned($signed(a_i) >>> shamt);
      ALU_SHL:  result_o[WIDTH-1:0] = a_i << shamt;
      ALU_ROR:  result_o[WIDTH-1:0] = rorWide[WIDTH-1:0];
      ALU_ROL:  result_o[WIDTH-1:0] = rolWide[2*WIDTH-1:WIDTH];
`ifdef DATAPATH_MULDIV_EN
      ALU_MUL:  result_o = $unsigned(product);
      ALU_DIV:  result_o = {$unsigned(remainder), $unsigned(quotient)};
`endif
      ALU_NEG:  result_o[WIDTH-1:0] = '0 - b_i;
      ALU_NOT:  result_o[WIDTH-1:0] = ~b_i;
      ALU_INC4: result_o[WIDTH-1:0] = b_i + WIDTH'(4);
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/mini_src_datapath.sv
// Mini SRC single-bus datapath: register file, special registers, bus mux,
// select-and-encode and CON flip-flop. Optional MUL/DIV via DATAPATH_MULDIV_EN.
module mini_src_datapath
  import mini_src_pkg::*;
#(
  parameter int               WIDTH    = DATA_WIDTH,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             MDROut,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHIout,
  input  logic             ZLOout,
  input  logic             Pout,
  input  logic             Cout,
  input  logic             Yout,
  input  logic             IRen,
  input  logic             MARen,
  input  logic             MDRen,
  input  logic             Read,
  input  logic             Write,
  input  logic             Yen,
  input  logic             Pen,
  input  logic             ZHIen,
  input  logic             ZLOen,
  input  logic             HIen,
  input  logic             LOen,
  input  logic             R0en,
  input  logic             R1en,
  input  logic             R2en,
  input  logic             R3en,
  input  logic             R4en,
  input  logic             R5en,
  input  logic             R6en,
  input  logic             R7en,
  input  logic             R8en,
  input  logic             R9en,
  input  logic             R10en,
  input  logic             R11en,
  input  logic             R12en,
  input  logic             R13en,
  input  logic             R14en,
  input  logic             R15en,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             BAout,
  input  logic             ConIn,
  input  logic             Rin,
  input  logic             Rout,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] mar_out,
  output logic [WIDTH-1:0] ir_out,
  output logic             con_out,
  output logic             mem_write
);

  logic [WIDTH-1:0] regFile_q [16];
  logic [WIDTH-1:0] hi_q, lo_q, zHi_q, zLo_q, pc_q, mdr_q, mar_q, ir_q, y_q;
  logic             con_q;

  logic [WIDTH-1:0]   mdr_d;
  logic               con_d;
  logic [WIDTH-1:0]   busValue;
  logic               busFound;
  logic [WIDTH-1:0]   cSext;
  logic [2*WIDTH-1:0] aluResult;

  logic [15:0]         rOutStrobe, rEnStrobe, selOneHot, regDrive, regLoad;
  logic [IR_REG_W-1:0] raField, rbField, rcField, selIdx;
  logic                baZero;

  assign rOutStrobe = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign rEnStrobe  = {R15en, R14en, R13en, R12en, R11en, R10en, R9en, R8en,
                       R7en,  R6en,  R5en,  R4en,  R3en,  R2en,  R1en, R0en};

  // Select-and-encode: gated IR register fields ORed into one index.
  assign raField   = ir_q[IR_RA_LSB +: IR_REG_W];
  assign rbField   = ir_q[IR_RB_LSB +: IR_REG_W];
  assign rcField   = ir_q[IR_RC_LSB +: IR_REG_W];
  assign selIdx    = ({IR_REG_W{Gra}} & raField) | ({IR_REG_W{Grb}} & rbField) |
                     ({IR_REG_W{Grc}} & rcField);
  assign selOneHot = 16'b1 << selIdx;
  assign regLoad   = rEnStrobe | ({16{Rin}} & selOneHot);
  assign regDrive  = rOutStrobe | ({16{Rout | BAout}} & selOneHot);
  // R0 reads as zero only when it reaches the bus purely through BAout.
  assign baZero    = BAout & selOneHot[0] & ~R0out & ~Rout;

  assign cSext = {{(WIDTH-IR_C_MSB-1){ir_q[IR_C_MSB]}}, ir_q[IR_C_MSB:0]};

  // Fixed-priority bus mux: R0 highest, C_sext lowest, zero when undriven.
  always_comb begin
    busValue = '0;
    busFound = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!busFound && regDrive[i]) begin
        busFound = 1'b1;
        busValue = ((i == 0) && baZero) ? '0 : regFile_q[i];
      end
    end
    if (!busFound) begin
      if (HIout)       busValue = hi_q;
      else if (LOout)  busValue = lo_q;
      else if (ZHIout) busValue = zHi_q;
      else if (ZLOout) busValue = zLo_q;
      else if (Pout)   busValue = pc_q;
      else if (MDROut) busValue = mdr_q;
      else if (Yout)   busValue = y_q;
      else if (Cout)   busValue = cSext;
      else             busValue = '0;
    end
  end

  mini_src_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i    (alu_control),
    .a_i     (y_q),
    .b_i     (busValue),
    .result_o(aluResult)
  );

  assign mdr_d = Read ? Mdatain : busValue;
  assign con_d = conditionMet(ir_q[IR_CON_LSB +: 2], busValue);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) regFile_q[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (regLoad[i]) regFile_q[i] <= busValue;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi_q  <= '0;
      lo_q  <= '0;
      zHi_q <= '0;
      zLo_q <= '0;
      pc_q  <= PC_RESET;
      mdr_q <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      con_q <= 1'b0;
    end else begin
      if (HIen)  hi_q  <= busValue;
      if (LOen)  lo_q  <= busValue;
      if (ZHIen) zHi_q <= aluResult[2*WIDTH-1:WIDTH];
      if (ZLOen) zLo_q <= aluResult[WIDTH-1:0];
      if (Pen)   pc_q  <= busValue;
      if (MDRen) mdr_q <= mdr_d;
      if (MARen) mar_q <= busValue;
      if (IRen)  ir_q  <= busValue;
      if (Yen)   y_q   <= busValue;
      if (ConIn) con_q <= con_d;
    end
  end

  assign bus_out   = busValue;
  assign mar_out   = mar_q;
  assign ir_out    = ir_q;
  assign con_out   = con_q;
  assign mem_write = Write;

endmodule

// File: tb/tb_mini_src_datapath.sv
// Self-checking bench for mini_src_datapath: directed sequences plus randomized
// ALU, select-and-encode, CON and bus-priority checks against a behavioural model.
module tb_mini_src_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  aluSel;
  logic [31:0] Mdatain;
  logic [15:0] rOut, rEn;
  logic mdrOut, hiOut, loOut, zhiOut, zloOut, pOut, cOut, yOut;
  logic irEn, marEn, mdrEn, readSig, writeSig;
  logic yEn, pEn, zhiEn, zloEn, hiEn, loEn;
  logic gra, grb, grc, baOut, conIn, rinSig, routSig;
  logic [31:0] bus_out, mar_out, ir_out;
  logic        con_out, mem_write;

  always #5 clk = ~clk;

  mini_src_datapath #(.WIDTH(32), .PC_RESET(32'h0)) dut (
    .clk(clk), .clr(clr), .alu_control(aluSel), .Mdatain(Mdatain),
    .R0out(rOut[0]), .R1out(rOut[1]), .R2out(rOut[2]), .R3out(rOut[3]),
    .R4out(rOut[4]), .R5out(rOut[5]), .R6out(rOut[6]), .R7out(rOut[7]),
    .R8out(rOut[8]), .R9out(rOut[9]), .R10out(rOut[10]), .R11out(rOut[11]),
    .R12out(rOut[12]), .R13out(rOut[13]), .R14out(rOut[14]), .R15out(rOut[15]),
    .MDROut(mdrOut), .HIout(hiOut), .LOout(loOut), .ZHIout(zhiOut),
    .ZLOout(zloOut), .Pout(pOut), .Cout(cOut), .Yout(yOut),
    .IRen(irEn), .MARen(marEn), .MDRen(mdrEn), .Read(readSig), .Write(writeSig),
    .Yen(yEn), .Pen(pEn), .ZHIen(zhiEn), .ZLOen(zloEn), .HIen(hiEn), .LOen(loEn),
    .R0en(rEn[0]), .R1en(rEn[1]), .R2en(rEn[2]), .R3en(rEn[3]),
    .R4en(rEn[4]), .R5en(rEn[5]), .R6en(rEn[6]), .R7en(rEn[7]),
    .R8en(rEn[8]), .R9en(rEn[9]), .R10en(rEn[10]), .R11en(rEn[11]),
    .R12en(rEn[12]), .R13en(rEn[13]), .R14en(rEn[14]), .R15en(rEn[15]),
    .Gra(gra), .Grb(grb), .Grc(grc), .BAout(baOut), .ConIn(conIn),
    .Rin(rinSig), .Rout(routSig),
    .bus_out(bus_out), .mar_out(mar_out), .ir_out(ir_out),
    .con_out(con_out), .mem_write(mem_write)
  );

  int nChecks = 0;
  int nErrors = 0;

  logic [31:0] refR [16];
  logic [31:0] refHi, refLo, refZHi, refZLo, refPc, refMdr, refY, refIr, refMar;

  task automatic resetModel();
    for (int i = 0; i < 16; i++) refR[i] = '0;
    refHi = '0; refLo = '0; refZHi = '0; refZLo = '0; refPc = '0;
    refMdr = '0; refY = '0; refIr = '0; refMar = '0;
  endtask

  task automatic clearControls();
    aluSel = '0; rOut = '0; rEn = '0;
    mdrOut = 0; hiOut = 0; loOut = 0; zhiOut = 0; zloOut = 0; pOut = 0; cOut = 0; yOut = 0;
    irEn = 0; marEn = 0; mdrEn = 0; readSig = 0; writeSig = 0;
    yEn = 0; pEn = 0; zhiEn = 0; zloEn = 0; hiEn = 0; loEn = 0;
    gra = 0; grb = 0; grc = 0; baOut = 0; conIn = 0; rinSig = 0; routSig = 0;
  endtask

  // Clock the currently asserted strobes once, then drop them.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearControls();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic expectBus(input string tag, input logic [31:0] exp);
    #1;
    checkOutput(tag, bus_out, exp);
    clearControls();
  endtask

  task automatic writeMdr(input logic [31:0] value);
    Mdatain = value; readSig = 1; mdrEn = 1;
    applyStimulus();
    refMdr = value;
  endtask

  task automatic writeReg(input int idx, input logic [31:0] value);
    writeMdr(value);
    mdrOut = 1; rEn[idx] = 1;
    applyStimulus();
    refR[idx] = value;
  endtask

  task automatic loadIr(input logic [31:0] value);
    writeMdr(value);
    mdrOut = 1; irEn = 1;
    applyStimulus();
    refIr = value;
  endtask

  function automatic logic [31:0] sextRef(input logic [31:0] ir);
    logic [31:0] low;
    low = {13'b0, ir[18:0]};
    return (low >= 32'h0004_0000) ? low - 32'h0008_0000 : low;
  endfunction

  function automatic logic conRef(input logic [1:0] code, input logic [31:0] v);
    case (code)
      2'd0:    return v == 0;
      2'd1:    return v != 0;
      2'd2:    return int'(v) >= 0;
      default: return int'(v) < 0;
    endcase
  endfunction

  function automatic logic [63:0] aluRef(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] lo, hi;
    int s;
    s = int'(b[4:0]);
    lo = 0; hi = 0;
    case (op)
      5'd0:  lo = a + b;
      5'd1:  lo = a - b;
      5'd2:  lo = a & b;
      5'd3:  lo = a | b;
      5'd4:  lo = a >> s;
      5'd5:  lo = a[31] ? ~((~a) >> s) : (a >> s);
      5'd6:  lo = a << s;
      5'd7:  lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      5'd8:  lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
`ifdef DATAPATH_MULDIV_EN
      5'd9: begin
        longint p;
        p = longint'(int'(a)) * longint'(int'(b));
        {hi, lo} = p;
      end
      5'd10: begin
        if (b != 0) begin
          lo = int'(a) / int'(b);
          hi = int'(a) % int'(b);
        end
      end
`endif
      5'd11: lo = 32'd0 - b;
      5'd12: lo = ~b;
      5'd13: lo = b + 32'd4;
      default: begin lo = 0; hi = 0; end
    endcase
    return {hi, lo};
  endfunction

  // Driver bits in priority order: R0..R15, HI, LO, ZHI, ZLO, PC, MDR, Y, C_sext.
  function automatic logic [31:0] busRef(input logic [23:0] drv);
    logic [31:0] vals [24];
    for (int i = 0; i < 16; i++) vals[i] = refR[i];
    vals[16] = refHi; vals[17] = refLo; vals[18] = refZHi; vals[19] = refZLo;
    vals[20] = refPc; vals[21] = refMdr; vals[22] = refY; vals[23] = sextRef(refIr);
    for (int i = 0; i < 24; i++) if (drv[i]) return vals[i];
    return 32'h0;
  endfunction

  initial begin
    logic [31:0] a, b, v, ir;
    logic [63:0] z;
    logic [4:0]  op;
    logic [23:0] drv;
    logic [1:0]  code;
    logic [2:0]  g;
    logic [3:0]  idx;

    clearControls();
    clr = 0; Mdatain = 0;
    resetModel();
    #2;
    checkOutput("reset_bus", bus_out, 0);
    checkOutput("reset_mar", mar_out, 0);
    checkOutput("reset_ir", ir_out, 0);
    checkOutput("reset_con", {31'b0, con_out}, 0);
    @(posedge clk); #1;
    clr = 1;

    // Preload state, then reset asynchronously in the middle of a PC load.
    writeReg(1, 32'hDEAD_BEEF);
    writeMdr(32'h0000_0044);
    mdrOut = 1; pEn = 1; applyStimulus(); refPc = 32'h44;
    pOut = 1; marEn = 1; applyStimulus(); refMar = 32'h44;
    checkOutput("preload_mar", mar_out, refMar);
    loadIr(32'h1234_5678);
    checkOutput("preload_ir", ir_out, refIr);
    mdrOut = 1; pEn = 1;
    #3; clr = 0; #1;
    clearControls();
    resetModel();
    #1;
    checkOutput("midreset_mar", mar_out, 0);
    checkOutput("midreset_ir", ir_out, 0);
    pOut = 1;     expectBus("midreset_pc", 0);
    rOut[1] = 1;  expectBus("midreset_r1", 0);
    mdrOut = 1;   expectBus("midreset_mdr", 0);
    expectBus("midreset_nodrv", 0);
    @(posedge clk); #1;
    clr = 1;

    // MFHI sequence.
    writeMdr(32'h1234_5678);
    mdrOut = 1; hiEn = 1; applyStimulus(); refHi = 32'h1234_5678;
    pOut = 1; marEn = 1; applyStimulus();
    checkOutput("mfhi_t0_mar", mar_out, 32'h0);
    writeMdr(32'h9180_0000);
    mdrOut = 1; expectBus("mfhi_t1_mdr", 32'h9180_0000);
    mdrOut = 1; irEn = 1; applyStimulus(); refIr = 32'h9180_0000;
    checkOutput("mfhi_t2_ir", ir_out, 32'h9180_0000);
    gra = 1; rinSig = 1; hiOut = 1; applyStimulus(); refR[3] = refHi;
    rOut[3] = 1; expectBus("mfhi_t3_r3", 32'h1234_5678);

    // ADD 5 + 7.
    writeReg(2, 5);
    writeReg(3, 7);
    rOut[2] = 1; yEn = 1; applyStimulus(); refY = 5;
    rOut[3] = 1; aluSel = 5'b00000; zloEn = 1; applyStimulus(); refZLo = 12;
    zloOut = 1; expectBus("add_zlo", 32'd12);

    // BAout against Rout with rb selecting R0.
    writeReg(0, 32'hFFFF_FFFF);
    loadIr(32'h0000_0000);
    grb = 1; baOut = 1;   expectBus("baout_r0", 32'h0);
    grb = 1; routSig = 1; expectBus("rout_r0", 32'hFFFF_FFFF);

    // C_sext.
    loadIr(32'h0007_FFFF);
    cOut = 1; expectBus("csext_neg", 32'hFFFF_FFFF);
    loadIr(32'h0000_0010);
    cOut = 1; expectBus("csext_pos", 32'h0000_0010);

    // CON with code 11 (<0).
    loadIr(32'h0018_0000);
    writeReg(4, 32'h8000_0000);
    rOut[4] = 1; conIn = 1; applyStimulus();
    checkOutput("con_lt_neg", {31'b0, con_out}, 1);
    writeReg(5, 32'h1);
    rOut[5] = 1; conIn = 1; applyStimulus();
    checkOutput("con_lt_pos", {31'b0, con_out}, 0);

    writeSig = 1; #1;
    checkOutput("mem_write", {31'b0, mem_write}, 1);
    clearControls();
    rOut[5] = 1; hiOut = 1; expectBus("prio_r5_hi", refR[5]);

    // Randomized select-and-encode.
    for (int n = 0; n < 6; n++) begin
      ir = $urandom;
      loadIr(ir);
      g = 3'($urandom_range(1, 7));
      idx = (g[0] ? ir[26:23] : 4'h0) | (g[1] ? ir[22:19] : 4'h0) | (g[2] ? ir[18:15] : 4'h0);
      v = $urandom;
      writeMdr(v);
      mdrOut = 1; {grc, grb, gra} = g; rinSig = 1; applyStimulus();
      refR[idx] = v;
      {grc, grb, gra} = g; routSig = 1;
      expectBus($sformatf("selenc_%0d_r%0d", n, idx), refR[idx]);
      rOut[idx] = 1;
      expectBus($sformatf("selenc_direct_%0d", n), v);
    end

    // Randomized ALU operations (A from Y, B from bus).
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = (n % 7 == 3) ? 32'h0 : $urandom;
      op = 5'($urandom_range(0, 15));
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
      writeReg(8, a);
      writeReg(9, b);
      rOut[8] = 1; yEn = 1; applyStimulus(); refY = a;
      rOut[9] = 1; aluSel = op; zloEn = 1; zhiEn = 1; applyStimulus();
      z = aluRef(op, a, b);
      refZHi = z[63:32]; refZLo = z[31:0];
      zloOut = 1; expectBus($sformatf("alu_op%0d_lo a=%08h b=%08h", op, a, b), refZLo);
      zhiOut = 1; expectBus($sformatf("alu_op%0d_hi a=%08h b=%08h", op, a, b), refZHi);
    end

    // Randomized CON conditions.
    for (int n = 0; n < 8; n++) begin
      code = 2'(n % 4);
      case ($urandom_range(0, 2))
        0:       v = 32'h0;
        1:       v = $urandom | 32'h8000_0000;
        default: v = $urandom;
      endcase
      loadIr({11'b0, code, 19'b0});
      writeReg(10, v);
      rOut[10] = 1; conIn = 1; applyStimulus();
      checkOutput($sformatf("con_code%0d_v%08h", code, v), {31'b0, con_out}, {31'b0, conRef(code, v)});
    end

    // Randomized bus priority with several drivers at once.
    writeMdr($urandom); mdrOut = 1; hiEn = 1; applyStimulus(); refHi = refMdr;
    writeMdr($urandom); mdrOut = 1; loEn = 1; applyStimulus(); refLo = refMdr;
    writeMdr($urandom); mdrOut = 1; pEn = 1;  applyStimulus(); refPc = refMdr;
    writeMdr($urandom); mdrOut = 1; yEn = 1;  applyStimulus(); refY = refMdr;
    loadIr($urandom);
    for (int n = 0; n < 20; n++) begin
      drv = 24'($urandom & $urandom & $urandom);
      if (n == 0) drv = 24'h0;
      rOut = drv[15:0];
      hiOut = drv[16]; loOut = drv[17]; zhiOut = drv[18]; zloOut = drv[19];
      pOut = drv[20]; mdrOut = drv[21]; yOut = drv[22]; cOut = drv[23];
      expectBus($sformatf("prio_%0d_drv%06h", n, drv), busRef(drv));
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mini_src_datapath.md
Name: mini_src_datapath

Overview:
- 32-bit single-bus datapath for the Mini SRC CPU.
- Contains the register file, special registers, ALU, select-and-encode logic and the CON flip-flop.
- Driven cycle-by-cycle by an external control unit (or bench) through one-hot bus-drive (…out) and register-load (…en) strobes.
- Memory sits outside the block: read data arrives on Mdatain.

Parameters:
- WIDTH, 32, bus/register width (only 32 supported)
- PC_RESET, 32'h0000_0000, PC value after reset

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-low reset
- alu_control  input  5  ALU operation code
- Mdatain  input  32  memory read data
- R0out..R15out  input  1 each  drive R0..R15 onto bus
- MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout  input  1 each  drive MDR/HI/LO/Z[63:32]/Z[31:0]/PC/C_sext/Y onto bus
- IRen, MARen, MDRen  input  1 each  load IR/MAR/MDR
- Read, Write  input  1 each  MDR source select; memory write strobe (passed through only)
- Yen, Pen, ZHIen, ZLOen, HIen, LOen  input  1 each  load Y/PC/Z[63:32]/Z[31:0]/HI/LO
- R0en..R15en  input  1 each  load R0..R15
- Gra, Grb, Grc, BAout, ConIn, Rin, Rout  input  1 each  select-and-encode and CON controls
- bus_out  output  32  current bus value
- mar_out  output  32  MAR contents (memory address)
- ir_out  output  32  IR contents
- con_out  output  1  CON flip-flop
- mem_write  output  1  equals Write

Behaviour:
- Reset: clr=0 asynchronously clears R0–R15, HI, LO, IR, MAR, MDR, Y, Z and CON to 0, and sets PC to PC_RESET. All registered outputs read 0 while clr=0 (mar_out=0 when PC_RESET=0).
- Register loads: every register loads from the bus on the rising clk edge while its enable is 1; otherwise it holds. Single-cycle latency.
- MDR load: when MDRen=1, MDR loads Mdatain if Read=1, else the bus.
- Bus: combinational mux.
  - Fixed priority: R0..R15, HI, LO, ZHI, ZLO, PC, MDR, Y, C_sext.
  - No driver asserted → bus = 0.
  - Multiple drivers asserted → highest priority wins; this is a control error but must be deterministic.
- Select-and-encode, from IR fields ra=IR[26:23], rb=IR[22:19], rc=IR[18:15]:
  - Selected index = (Gra?ra)|(Grb?rb)|(Grc?rc).
  - Rin asserts Rxen for the selected register; Rout drives the selected register onto the bus.
  - Both are ORed with the explicit Rxen/Rxout strobes.
- BAout: acts like Rout, except a selected R0 drives 0 onto the bus.
- C_sext = sign-extend(IR[18:0]).
- ALU: A=Y, B=bus, 64-bit result to Z; Z[63:32] loads on ZHIen, Z[31:0] on ZLOen. Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SHR, 00101 SHRA, 00110 SHL
  - 00111 ROR, 01000 ROL (shift amount B[4:0])
  - 01001 MUL (signed A*B, 64-bit), 01010 DIV (LO=quotient in Z[31:0], HI=remainder in Z[63:32]; B=0 → Z=0)
  - 01011 NEG(B), 01100 NOT(B), 01101 INC4 (B+4)
  - Others → 0
  - For 32-bit ops Z[63:32] is sign/zero-ignored and set to 0; ADD/SUB wrap modulo 2^32.
- CON: on clk edge with ConIn=1, CON loads a condition on the bus value selected by IR[20:19]: 00 zero, 01 nonzero, 10 ≥0 (bit31=0), 11 <0.
- Simultaneous load and drive of the same register: the register updates with the pre-edge bus value (ordinary flop semantics).

Optional Feature:
- Macro DATAPATH_MULDIV_EN.
- Defined: MUL and DIV (01001, 01010) are implemented as above.
- Undefined: those codes produce Z=0. No multiplier or divider logic is synthesized. All other behaviour is unchanged.

Decomposition:
- Shared package mini_src_pkg holds the ALU opcode constants, WIDTH, IR field bit positions and CON condition codes.
- One sub-module, mini_src_alu: combinational 64-bit result from (op, A, B).
- Registers, bus mux and select-and-encode stay in the top level.

Test Plan:
- Reset: clr=0 mid-operation with Pen=1 → all registers 0 immediately; bus=0 with no drivers.
- MFHI sequence, after HI=32'h1234_5678 loaded via bus, PC=0:
  - T0 Pout+MARen → mar_out=0
  - T1 Read+MDRen with Mdatain=32'h9180_0000 (ra=3) → MDR=32'h9180_0000
  - T2 MDROut+IRen → ir_out=32'h9180_0000
  - T3 Gra+Rin+HIout → R3=32'h1234_5678
- ADD: R2=5, R3=7; R2out+Yen, then R3out with alu_control=00000 and ZLOen → Z[31:0]=12. ZLOout → bus_out=12.
- BAout: IR selects rb=0, R0=32'hFFFF_FFFF; Grb+BAout → bus_out=0. Grb+Rout → bus_out=32'hFFFF_FFFF.
- Cout: IR[18:0]=19'h7FFFF → bus_out=32'hFFFF_FFFF. IR[18:0]=19'h00010 → 32'h10.
- CON: IR[20:19]=11, bus=32'h8000_0000, ConIn=1 → con_out=1. Bus=1 → con_out=0.
